// File: rtl/rgb_block_serializer.sv
// Two-slot ping-pong buffer for 8x8 RGB blocks, streamed one pixel per cycle
// with absolute image coordinates and block/frame markers.
module rgb_block_serializer #(
  parameter int unsigned W_BLK = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [7:0][7:0][7:0]         r,
  input  logic [7:0][7:0][7:0]         g,
  input  logic [7:0][7:0][7:0]         b,
  output logic                         ready_in,
  input  logic [W_BLK-1:0]             width_blks,
  input  logic [W_BLK-1:0]             height_blks,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [7:0]                   pix_r,
  output logic [7:0]                   pix_g,
  output logic [7:0]                   pix_b,
  output logic [W_BLK+2:0]             pix_x,
  output logic [W_BLK+2:0]             pix_y,
  output logic                         sob,
  output logic                         eob,
  output logic                         eof,
  output logic                         overflow
);

  localparam int unsigned W_PIX = W_BLK + 3;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                     state;
  logic [1:0]                 cnt;
  logic [1:0]                 cnt_nxt;
  logic                       wp;
  logic                       rp;
  logic [5:0]                 idx;
  logic [W_BLK-1:0]           bc;
  logic [W_BLK-1:0]           br;
  logic [W_BLK-1:0]           w_lat;
  logic [W_BLK-1:0]           h_lat;
  logic [1:0][7:0][7:0][7:0]  mem_r;
  logic [1:0][7:0][7:0][7:0]  mem_g;
  logic [1:0][7:0][7:0][7:0]  mem_b;

  logic       wr_en;
  logic       drop;
  logic       hs;
  logic       last_pix;
  logic       pop;
  logic       last_col;
  logic       last_row;
  logic       first_blk;
  logic [2:0] row;
  logic [2:0] col;

  assign wr_en     = valid_in && (cnt != 2'd2);
  assign drop      = valid_in && (cnt == 2'd2);
  assign pix_valid = (state == S_STREAM);
  assign hs        = pix_valid && pix_ready;
  assign last_pix  = (idx == 6'd63);
  assign pop       = hs && last_pix;
  assign cnt_nxt   = cnt + 2'(wr_en) - 2'(pop);
  assign ready_in  = (cnt != 2'd2);
  assign last_col  = (bc >= w_lat - W_BLK'(1));
  assign last_row  = (br >= h_lat - W_BLK'(1));
  assign first_blk = (bc == '0) && (br == '0);
  assign row       = idx[5:3];
  assign col       = idx[2:0];

  // Presentation is gated by pix_valid so every pix_* output reads zero when idle.
  assign pix_r = pix_valid ? mem_r[rp][row][col] : 8'd0;
  assign pix_g = pix_valid ? mem_g[rp][row][col] : 8'd0;
  assign pix_b = pix_valid ? mem_b[rp][row][col] : 8'd0;
  assign pix_x = pix_valid ? W_PIX'({bc, col}) : '0;
  assign pix_y = pix_valid ? W_PIX'({br, row}) : '0;
  assign sob   = pix_valid && (idx == 6'd0);
  assign eob   = pix_valid && last_pix;
  assign eof   = eob && last_col && last_row;

  // Block storage: a whole block lands in slot wp in one cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wp] <= r;
      mem_g[wp] <= g;
      mem_b[wp] <= b;
    end
  end

  // Occupancy, read FSM, pixel index and block position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      idx      <= 6'd0;
      bc       <= '0;
      br       <= '0;
      w_lat    <= W_BLK'(1);
      h_lat    <= W_BLK'(1);
      overflow <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      state <= (cnt_nxt != 2'd0) ? S_STREAM : S_IDLE;
      if (wr_en) wp <= ~wp;
      if (drop) overflow <= 1'b1;
      // Frame size is captured while the first pixel of block (0,0) is presented.
      if (pix_valid && (idx == 6'd0) && first_blk) begin
        w_lat <= (width_blks == '0) ? W_BLK'(1) : width_blks;
        h_lat <= (height_blks == '0) ? W_BLK'(1) : height_blks;
      end
      if (hs) begin
        idx <= idx + 6'd1;
        if (last_pix) begin
          rp <= ~rp;
          if (last_col) begin
            bc <= '0;
            br <= last_row ? '0 : br + W_BLK'(1);
          end else begin
            bc <= bc + W_BLK'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_block_serializer.sv
// Scoreboard bench for rgb_block_serializer: expected pixels are queued when a
// block is driven and compared as the DUT hands them out.
module tb_rgb_block_serializer;

  localparam int unsigned W_BLK = 8;
  localparam int unsigned W_PIX = W_BLK + 3;

  typedef struct packed {
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    logic [W_PIX-1:0] x;
    logic [W_PIX-1:0] y;
    logic             sob;
    logic             eob;
    logic             eof;
  } pix_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic [7:0][7:0][7:0] r;
  logic [7:0][7:0][7:0] g;
  logic [7:0][7:0][7:0] b;
  logic                 ready_in;
  logic [W_BLK-1:0]     width_blks;
  logic [W_BLK-1:0]     height_blks;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [7:0]           pix_r;
  logic [7:0]           pix_g;
  logic [7:0]           pix_b;
  logic [W_PIX-1:0]     pix_x;
  logic [W_PIX-1:0]     pix_y;
  logic                 sob;
  logic                 eob;
  logic                 eof;
  logic                 overflow;

  pix_t q[$];
  pix_t snap;
  logic stalled = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ready_mode = 0;

  rgb_block_serializer #(.W_BLK(W_BLK)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .r(r), .g(g), .b(b),
    .ready_in(ready_in), .width_blks(width_blks), .height_blks(height_blks),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .sob(sob), .eob(eob), .eof(eof), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One clock: sample at negedge (stability + scoreboard), then step past posedge.
  task automatic tick();
    pix_t obs;
    pix_t exp;
    @(negedge clk);
    obs = {pix_r, pix_g, pix_b, pix_x, pix_y, sob, eob, eof};
    if (stalled) begin
      vectors++;
      if (obs !== snap) begin
        miscompares++;
        $display("FAIL stall_hold: got %h required %h", obs, snap);
      end
    end
    if (pix_valid && pix_ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL extra_pixel: got %h required no pixel", obs);
      end else begin
        exp = q.pop_front();
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL pixel: got r=%h g=%h b=%h x=%0d y=%0d sob=%b eob=%b eof=%b required r=%h g=%h b=%h x=%0d y=%0d sob=%b eob=%b eof=%b",
                   obs.r, obs.g, obs.b, obs.x, obs.y, obs.sob, obs.eob, obs.eof,
                   exp.r, exp.g, exp.b, exp.x, exp.y, exp.sob, exp.eob, exp.eof);
        end
      end
    end
    stalled = pix_valid && !pix_ready && rst;
    snap = obs;
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b0;
    endcase
  endtask

  task automatic set_block(input logic [7:0] seed);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        r[i][j] = 8'(int'(seed) + 8 * i + j);
        g[i][j] = ~r[i][j];
        b[i][j] = seed ^ 8'h55;
      end
    end
  endtask

  task automatic push_block(input logic [7:0] seed, input int bx, input int by, input bit last);
    pix_t p;
    for (int k = 0; k < 64; k++) begin
      p.r   = 8'(int'(seed) + k);
      p.g   = ~p.r;
      p.b   = seed ^ 8'h55;
      p.x   = W_PIX'(bx * 8 + k % 8);
      p.y   = W_PIX'(by * 8 + k / 8);
      p.sob = (k == 0);
      p.eob = (k == 63);
      p.eof = (k == 63) && last;
      q.push_back(p);
    end
  endtask

  task automatic pulse(input logic [7:0] seed);
    set_block(seed);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    valid_in = 1'b0;
    q.delete();
    stalled = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    tick();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pixels outstanding required 0", q.size());
    end
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_idle: got pix_valid=%b required 0", pix_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    vectors++;
    if ({pix_valid, ready_in, overflow, sob, eob, eof} !== 6'b010000) begin
      miscompares++;
      $display("FAIL reset_flags: got v=%b rdy=%b ovf=%b sob=%b eob=%b eof=%b required 0 1 0 0 0 0",
               pix_valid, ready_in, overflow, sob, eob, eof);
    end
    vectors++;
    if ({pix_r, pix_g, pix_b, pix_x, pix_y} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got r=%h g=%h b=%h x=%0d y=%0d required all 0",
               pix_r, pix_g, pix_b, pix_x, pix_y);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    ready_mode = 0;
    width_blks = 8'd1;
    height_blks = 8'd1;
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pre_valid: got %b required 0", pix_valid);
    end
    push_block(8'd0, 0, 0, 1'b1);
    pulse(8'd0);
    vectors++;
    if (pix_valid !== 1'b1 || sob !== 1'b1) begin
      miscompares++;
      $display("FAIL single_first_valid: got valid=%b sob=%b required 1 1", pix_valid, sob);
    end
    drain(200);
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready_mode = 1;
    push_block(8'd7, 0, 0, 1'b1);
    pulse(8'd7);
    drain(2000);
    ready_mode = 0;
    pix_ready = 1'b1;
  endtask

  task automatic test_2x2();
    apply_reset();
    ready_mode = 0;
    width_blks = 8'd2;
    height_blks = 8'd2;
    for (int k = 0; k < 5; k++) begin
      push_block(8'(16 * k + 3), (k % 4) % 2, (k % 4) / 2, k == 3);
      pulse(8'(16 * k + 3));
      if (k < 4) repeat (63) tick();
    end
    drain(200);
  endtask

  task automatic test_overflow();
    apply_reset();
    width_blks = 8'd1;
    height_blks = 8'd1;
    ready_mode = 2;
    pix_ready = 1'b0;
    push_block(8'd40, 0, 0, 1'b1);
    push_block(8'd90, 0, 0, 1'b1);
    pulse(8'd40);
    vectors++;
    if (ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_ready1: got %b required 1", ready_in);
    end
    pulse(8'd90);
    vectors++;
    if (ready_in !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_ready2: got rdy=%b ovf=%b required 0 0", ready_in, overflow);
    end
    pulse(8'd150);
    vectors++;
    if (ready_in !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drop: got rdy=%b ovf=%b required 0 1", ready_in, overflow);
    end
    repeat (3) tick();
    ready_mode = 0;
    pix_ready = 1'b1;
    drain(300);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: got %b required 1", overflow);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ready_mode = 0;
    width_blks = 8'd1;
    height_blks = 8'd1;
    push_block(8'd10, 0, 0, 1'b1);
    push_block(8'd80, 0, 0, 1'b1);
    push_block(8'd200, 0, 0, 1'b1);
    pulse(8'd10);
    repeat (63) tick();
    pulse(8'd80);
    vectors++;
    if (pix_valid !== 1'b1 || sob !== 1'b1 || pix_r !== 8'd80 || ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_no_bubble: got v=%b sob=%b r=%h rdy=%b required 1 1 50 1",
               pix_valid, sob, pix_r, ready_in);
    end
    repeat (9) tick();
    pulse(8'd200);
    vectors++;
    if (ready_in !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full: got rdy=%b required 0", ready_in);
    end
    repeat (53) tick();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_pre_ovf: got %b required 0", overflow);
    end
    pulse(8'd33);
    vectors++;
    if (overflow !== 1'b1 || ready_in !== 1'b1 || sob !== 1'b1 || pix_r !== 8'd200) begin
      miscompares++;
      $display("FAIL b2b_drop: got ovf=%b rdy=%b sob=%b r=%h required 1 1 1 c8",
               overflow, ready_in, sob, pix_r);
    end
    drain(200);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    ready_mode = 0;
    width_blks = 8'd2;
    height_blks = 8'd2;
    push_block(8'd1, 0, 0, 1'b0);
    push_block(8'd120, 1, 0, 1'b0);
    pulse(8'd1);
    pulse(8'd120);
    while (q.size() > 44 && n < 500) begin
      tick();
      n++;
    end
    vectors++;
    if (pix_x !== W_PIX'(12) || pix_y !== W_PIX'(2) || pix_r !== 8'd140) begin
      miscompares++;
      $display("FAIL mid_position: got x=%0d y=%0d r=%h required 12 2 8c", pix_x, pix_y, pix_r);
    end
    rst = 1'b0;
    q.delete();
    stalled = 1'b0;
    #1;
    vectors++;
    if ({pix_valid, ready_in, overflow, sob, eob, eof} !== 6'b010000 ||
        {pix_r, pix_g, pix_b, pix_x, pix_y} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b rdy=%b ovf=%b r=%h x=%0d y=%0d required 0 1 0 0 0 0",
               pix_valid, ready_in, overflow, pix_r, pix_x, pix_y);
    end
    tick();
    rst = 1'b1;
    tick();
    push_block(8'd60, 0, 0, 1'b0);
    pulse(8'd60);
    vectors++;
    if (pix_valid !== 1'b1 || sob !== 1'b1 || pix_x !== '0 || pix_y !== '0) begin
      miscompares++;
      $display("FAIL mid_restart: got v=%b sob=%b x=%0d y=%0d required 1 1 0 0",
               pix_valid, sob, pix_x, pix_y);
    end
    drain(200);
  endtask

  initial begin
    valid_in = 1'b0;
    pix_ready = 1'b1;
    width_blks = 8'd1;
    height_blks = 8'd1;
    r = '0;
    g = '0;
    b = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_2x2();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
